// File: rtl/cpu_run_controller.sv
// Run/halt/single-step controller: turns the synchronized CPU-rate tick into
// gated one-cycle cpu_en strobes under operator buttons and CPU halt requests.

module cpu_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync;
  logic            level;
  logic [DB_W-1:0] cnt;

  // The synchronizer clears to 0, so the first two samples after reset read
  // "pressed". With a debounce count of 3 or more these never reach the limit.
  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == DB_MAX) begin
        level <= sync[1];
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module cpu_run_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             btn_run_n,
  input  logic             btn_step_n,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             running,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] tick_sync;
  logic       tick;
  logic       run_press;
  logic       step_press;
  logic       step_issued;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_sync <= 3'b000;
    end else begin
      tick_sync <= {tick_sync[1:0], tick_in};
    end
  end

  assign tick = tick_sync[1] & ~tick_sync[2];

  cpu_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_run_n),
    .press (run_press)
  );

  cpu_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_step_n),
    .press (step_press)
  );

  // Halt requests and run presses are resolved before the tick, so a
  // coinciding tick is dropped rather than leaking one last strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HALT;
      cpu_en      <= 1'b0;
      running     <= 1'b0;
      step_done   <= 1'b0;
      step_issued <= 1'b0;
    end else begin
      cpu_en      <= 1'b0;
      step_issued <= 1'b0;
      step_done   <= step_issued;
      unique case (state)
        ST_HALT: begin
          if (!halt_req) begin
            if (run_press) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end else if (step_press) begin
              state <= ST_STEP;
            end
          end
        end
        ST_RUN: begin
          if (halt_req || run_press) begin
            state   <= ST_HALT;
            running <= 1'b0;
          end else begin
            cpu_en <= tick;
          end
        end
        ST_STEP: begin
          if (halt_req) begin
            state <= ST_HALT;
          end else if (tick) begin
            cpu_en      <= 1'b1;
            step_issued <= 1'b1;
            state       <= ST_HALT;
          end
        end
        default: begin
          state   <= ST_HALT;
          running <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (cpu_en) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: expected strobe cycles are queued as
// ticks are driven and matched against cpu_en / step_done as they appear.

module tb_cpu_run_controller;

  localparam int DB = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          tick_in;
  logic          btn_run_n;
  logic          btn_step_n;
  logic          halt_req;
  logic          cpu_en;
  logic          running;
  logic          step_done;
  logic [CW-1:0] cycle_count;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int en_q[$];
  int sd_q[$];

  cpu_run_controller #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_in     (tick_in),
    .btn_run_n   (btn_run_n),
    .btn_step_n  (btn_step_n),
    .halt_req    (halt_req),
    .cpu_en      (cpu_en),
    .running     (running),
    .step_done   (step_done),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the head of its queue by cycle, and
  // a queue head that has gone stale is a missed strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_en) begin
        check("cpu_en_cycle", cyc, (en_q.size() != 0) ? en_q.pop_front() : -1);
      end else if (en_q.size() != 0 && en_q[0] < cyc) begin
        void'(en_q.pop_front());
        check("cpu_en_missing", int'(cpu_en), 1);
      end
      if (step_done) begin
        check("step_done_cycle", cyc, (sd_q.size() != 0) ? sd_q.pop_front() : -1);
      end else if (sd_q.size() != 0 && sd_q[0] < cyc) begin
        void'(sd_q.pop_front());
        check("step_done_missing", int'(step_done), 1);
      end
    end
  end

  task automatic do_ticks(input int n, input bit exp_en, input bit exp_done);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick_in = 1'b1;
      if (exp_en) en_q.push_back(cyc + 3);
      if (exp_done && i == 0) sd_q.push_back(cyc + 4);
      repeat (8) @(negedge clk);
      tick_in = 1'b0;
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic press(input bit run, input bit step, input int n);
    @(negedge clk);
    if (run) btn_run_n = 1'b0;
    if (step) btn_step_n = 1'b0;
    repeat (n) @(negedge clk);
    btn_run_n  = 1'b1;
    btn_step_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cpu_en"}, int'(cpu_en), 0);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_step_done"}, int'(step_done), 0);
    check({tag, "_count"}, int'(cycle_count), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    tick_in    = 1'b0;
    btn_run_n  = 1'b1;
    btn_step_n = 1'b1;
    halt_req   = 1'b0;

    // Reset held with tick_in toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tick_in = (i % 2 == 0);
      check_idle("reset");
    end
    @(negedge clk);
    tick_in = 1'b0;
    rst_n   = 1'b1;
    repeat (4) @(negedge clk);
    do_ticks(2, 1'b0, 1'b0);
    check("post_reset_running", int'(running), 0);
    check("post_reset_count", int'(cycle_count), 0);

    // Run: ten ticks, ten strobes
    press(1'b1, 1'b0, 10);
    check("run_running", int'(running), 1);
    do_ticks(10, 1'b1, 1'b0);
    check("run_count", int'(cycle_count), 10);

    // halt_req in the cycle the tick pulse is detected
    @(negedge clk);
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    check("collision_running", int'(running), 0);
    check("collision_cpu_en", int'(cpu_en), 0);
    repeat (5) @(negedge clk);
    tick_in = 1'b0;
    repeat (8) @(negedge clk);
    check("collision_count", int'(cycle_count), 10);

    // Bouncy run button: 2-cycle glitches never reach the debounce limit
    for (int i = 0; i < 10; i++) begin
      btn_run_n = 1'b0;
      repeat (2) @(negedge clk);
      btn_run_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce_running", int'(running), 0);
    do_ticks(1, 1'b0, 1'b0);
    check("bounce_count", int'(cycle_count), 10);

    // Single step: one strobe, step_done one cycle later, then silence
    press(1'b0, 1'b1, 10);
    check("step_running", int'(running), 0);
    do_ticks(1, 1'b1, 1'b1);
    do_ticks(2, 1'b0, 1'b0);
    check("step_count", int'(cycle_count), 11);
    check("step_running_after", int'(running), 0);

    // Simultaneous run+step press: run wins, ticks keep strobing
    press(1'b1, 1'b1, 10);
    check("both_running", int'(running), 1);
    do_ticks(2, 1'b1, 1'b0);
    check("both_count", int'(cycle_count), 13);
    press(1'b1, 1'b0, 10);
    check("run_toggle_off", int'(running), 0);
    do_ticks(1, 1'b0, 1'b0);
    check("halted_count", int'(cycle_count), 13);

    // Counter wrap with a 4-bit count
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst2");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    press(1'b1, 1'b0, 10);
    do_ticks(17, 1'b1, 1'b0);
    check("wrap_count", int'(cycle_count), 1);
    @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    check("halt_req_running", int'(running), 0);

    // Reset while a step is pending: the tick must not be honoured
    press(1'b0, 1'b1, 10);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("rst_mid_step");
    tick_in = 1'b1;
    repeat (8) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    check_idle("rst_mid_step_held");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_ticks(2, 1'b0, 1'b0);
    check_idle("after_rst_mid_step");

    repeat (4) @(negedge clk);
    check("en_queue_drained", en_q.size(), 0);
    check("sd_queue_drained", sd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
